cpu_speed_req: RTL and testbench
================================

CPU_SPEED_REQ -- requirements
Module: cpu_speed_req

Interface
REQ-001 The block SHALL have parameter HOST_BANK, default 8'hFF, meaning the CPU bank that maps to host (slow-clock) memory.
REQ-002 The block SHALL have parameter HOLD_SLOW, default 4 (legal 1..15), meaning the lsclk cycles to remain slow after the last host access.
REQ-003 The block SHALL have parameter HS_SETTLE, default 16 (legal 1..31), meaning the hsclk_in cycles allowed for the clock switch to complete a slow-to-fast change.
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
  hsclk_in  in  1  high-speed clock; the only clock of this block.
  rst_b  in  1  asynchronous active-low reset.
  lsclk_in  in  1  host clock; asynchronous to hsclk_in; sampled as data only.
  hs_enable  in  1  configuration bit; 1 permits fast running.
  cyc_start  in  1  one-hsclk_in-cycle pulse marking that a new CPU bus address is valid.
  cpu_vda  in  1  valid data address qualifier.
  cpu_vpa  in  1  valid program address qualifier.
  cpu_bank  in  8  CPU address bits 23:16.
  hsclk_sel  out  1  request to the clock switch; 1 = fast clock, 0 = host clock.
  cpu_rdy  out  1  0 = stretch/stall the CPU cycle.
  speed_fast  out  1  1 only in state FAST.

Function
REQ-005 lsclk_in SHALL pass through a 2-flop synchronizer on hsclk_in; an ls_edge pulse SHALL be generated on a synchronized 0->1 transition, so an lsclk rising edge is seen 2-3 hsclk_in cycles later.
REQ-006 host_acc SHALL equal cyc_start & (cpu_vda | cpu_vpa) & (cpu_bank == HOST_BANK).
REQ-007 The FSM SHALL have states FAST, TO_SLOW, SLOW and TO_FAST, registered on the rising edge of hsclk_in.
REQ-008 In FAST, host_acc or !hs_enable SHALL cause a transition to TO_SLOW on the next edge, with hsclk_sel<=0, cpu_rdy<=0 and the edge counter cleared.
REQ-009 TO_SLOW SHALL count ls_edge pulses; on the 2nd pulse the FSM SHALL move to SLOW with cpu_rdy<=1 and the hold counter loaded with HOLD_SLOW.
REQ-010 In SLOW, each ls_edge SHALL decrement the hold counter, saturating at 0.
REQ-011 In SLOW, host_acc SHALL reload the hold counter to HOLD_SLOW; a reload SHALL take priority over a decrement in the same cycle.
REQ-012 In SLOW, when hold==0 & hs_enable & !host_acc, the FSM SHALL move to TO_FAST with hsclk_sel<=1, cpu_rdy<=0 and the settle counter loaded with HS_SETTLE.
REQ-013 If host_acc coincides with hold reaching 0, the FSM SHALL remain in SLOW.
REQ-014 TO_FAST SHALL decrement the settle counter every hsclk_in cycle; when it reaches 0 the FSM SHALL move to FAST with cpu_rdy<=1.
REQ-015 TO_FAST SHALL NOT be aborted: a fall of hs_enable or a host_acc during TO_FAST SHALL be acted on only after FAST is reached.
REQ-016 TO_SLOW SHALL NOT be aborted by hs_enable rising.
REQ-017 The outputs hsclk_sel, cpu_rdy and speed_fast SHALL be registered and glitch-free; hsclk_sel SHALL change only on FSM transitions.
REQ-018 cpu_rdy SHALL be 0 exactly while in TO_SLOW or TO_FAST.

Reset
REQ-019 On rst_b=0, the block SHALL asynchronously set: state=SLOW, hsclk_sel=0, cpu_rdy=1, speed_fast=0, hold counter=0, settle counter=0, edge counter=0 and synchronizer flops=0, matching the clock switch's reset to host clock.
REQ-020 Reset asserted mid-transition SHALL return the block to SLOW with no intermediate output values.
REQ-021 Reset deassertion SHALL be consumed synchronously so that the first state change occurs no earlier than the 2nd hsclk_in edge after rst_b rises.

Verification
REQ-022 Reset release, hs_enable=1, no accesses -> SLOW, then after 4 ls_edges -> TO_FAST with hsclk_sel=1 and cpu_rdy=0, then after 16 hsclk_in cycles -> FAST with cpu_rdy=1 and speed_fast=1.
REQ-023 In FAST, cyc_start with vda=1 and bank=8'hFF -> next cycle hsclk_sel=0, cpu_rdy=0; cpu_rdy returns to 1 on the 2nd synchronized lsclk rising edge.
REQ-024 In FAST, cyc_start with bank=8'h7E or with vda=vpa=0 -> no change; hsclk_sel stays 1.
REQ-025 In SLOW, repeated host accesses every 3 lsclk cycles -> no TO_FAST; stop the accesses -> TO_FAST exactly 4 ls_edges after the last one; host_acc on the hold-0 cycle -> stays in SLOW.
REQ-026 hs_enable dropped in FAST -> TO_SLOW then SLOW; hs_enable dropped during TO_FAST -> FAST reached, then immediately TO_SLOW.
REQ-027 rst_b pulsed low during TO_FAST and during TO_SLOW -> immediately hsclk_sel=0, cpu_rdy=1, state SLOW.

Source files
------------

// File: rtl/cpu_speed_req.sv
// Fast/host clock speed arbiter: requests the high-speed clock unless the CPU
// touches the host bank, stalling the CPU while the clock switch changes over.
module cpu_speed_req #(
  parameter logic [7:0] HOST_BANK = 8'hFF,
  parameter int         HOLD_SLOW = 4,
  parameter int         HS_SETTLE = 16
) (
  input  logic       hsclk_in,
  input  logic       rst_b,
  input  logic       lsclk_in,
  input  logic       hs_enable,
  input  logic       cyc_start,
  input  logic       cpu_vda,
  input  logic       cpu_vpa,
  input  logic [7:0] cpu_bank,
  output logic       hsclk_sel,
  output logic       cpu_rdy,
  output logic       speed_fast
);

  typedef enum logic [1:0] {
    FAST    = 2'd0,
    TO_SLOW = 2'd1,
    SLOW    = 2'd2,
    TO_FAST = 2'd3
  } state_t;

  localparam logic [3:0] L_HOLD   = 4'(HOLD_SLOW);
  localparam logic [4:0] L_SETTLE = 5'(HS_SETTLE);

  logic [1:0] r_rst_sync;
  logic       r_ls_meta;
  logic       r_ls_sync;
  logic       r_ls_prev;
  state_t     r_state;
  logic [3:0] r_hold;
  logic [4:0] r_settle;
  logic       r_edge_cnt;
  logic       r_hsclk_sel;
  logic       r_cpu_rdy;
  logic       r_speed_fast;

  logic       w_run;
  logic       w_ls_edge;
  logic       w_host_acc;
  state_t     w_state_next;
  logic [3:0] w_hold_next;
  logic [4:0] w_settle_next;
  logic       w_edge_cnt_next;
  logic       w_sel_next;
  logic       w_rdy_next;
  logic       w_fast_next;

  // Release of rst_b is retimed so the FSM only starts two edges later.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_ls_meta <= 1'b0;
      r_ls_sync <= 1'b0;
      r_ls_prev <= 1'b0;
    end else begin
      r_ls_meta <= lsclk_in;
      r_ls_sync <= r_ls_meta;
      r_ls_prev <= r_ls_sync;
    end
  end

  assign w_ls_edge  = r_ls_sync & ~r_ls_prev;
  assign w_host_acc = cyc_start & (cpu_vda | cpu_vpa) & (cpu_bank == HOST_BANK);

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= SLOW;
      r_hold       <= 4'd0;
      r_settle     <= 5'd0;
      r_edge_cnt   <= 1'b0;
      r_hsclk_sel  <= 1'b0;
      r_cpu_rdy    <= 1'b1;
      r_speed_fast <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_hold       <= w_hold_next;
      r_settle     <= w_settle_next;
      r_edge_cnt   <= w_edge_cnt_next;
      r_hsclk_sel  <= w_sel_next;
      r_cpu_rdy    <= w_rdy_next;
      r_speed_fast <= w_fast_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_hold_next     = r_hold;
    w_settle_next   = r_settle;
    w_edge_cnt_next = r_edge_cnt;
    if (!w_run) begin
      // Leaving reset counts as entering SLOW: hold off the first speed-up.
      w_hold_next = L_HOLD;
    end else begin
      case (r_state)
        FAST: begin
          if (w_host_acc || !hs_enable) begin
            w_state_next    = TO_SLOW;
            w_edge_cnt_next = 1'b0;
          end
        end
        TO_SLOW: begin
          if (w_ls_edge) begin
            if (r_edge_cnt) begin
              w_state_next    = SLOW;
              w_hold_next     = L_HOLD;
              w_edge_cnt_next = 1'b0;
            end else begin
              w_edge_cnt_next = 1'b1;
            end
          end
        end
        SLOW: begin
          if (w_host_acc) begin
            w_hold_next = L_HOLD;
          end else if ((r_hold == 4'd0) && hs_enable) begin
            w_state_next  = TO_FAST;
            w_settle_next = L_SETTLE;
          end else if (w_ls_edge && (r_hold != 4'd0)) begin
            w_hold_next = r_hold - 4'd1;
          end
        end
        TO_FAST: begin
          if (r_settle <= 5'd1) begin
            w_state_next  = FAST;
            w_settle_next = 5'd0;
          end else begin
            w_settle_next = r_settle - 5'd1;
          end
        end
        default: begin
          w_state_next = SLOW;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch with the state flop.
  always_comb begin
    w_sel_next  = (w_state_next == TO_FAST) || (w_state_next == FAST);
    w_rdy_next  = (w_state_next == SLOW) || (w_state_next == FAST);
    w_fast_next = (w_state_next == FAST);
  end

  assign hsclk_sel  = r_hsclk_sel;
  assign cpu_rdy    = r_cpu_rdy;
  assign speed_fast = r_speed_fast;

endmodule

// File: tb/tb_cpu_speed_req.sv
// Directed bench for cpu_speed_req: every output change is matched against a
// queue of expected {hsclk_sel, cpu_rdy, speed_fast} values and arrival cycles.
module tb_cpu_speed_req;

  logic       hsclk_in  = 1'b0;
  logic       rst_b     = 1'b1;
  logic       lsclk_in  = 1'b0;
  logic       hs_enable = 1'b1;
  logic       cyc_start = 1'b0;
  logic       cpu_vda   = 1'b0;
  logic       cpu_vpa   = 1'b0;
  logic [7:0] cpu_bank  = 8'h00;
  logic       hsclk_sel;
  logic       cpu_rdy;
  logic       speed_fast;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    string      tag;
    logic [2:0] val;
    int         at_cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] mon_prev = 3'b010;

  cpu_speed_req #(
    .HOST_BANK(8'hFF),
    .HOLD_SLOW(4),
    .HS_SETTLE(16)
  ) dut (
    .hsclk_in  (hsclk_in),
    .rst_b     (rst_b),
    .lsclk_in  (lsclk_in),
    .hs_enable (hs_enable),
    .cyc_start (cyc_start),
    .cpu_vda   (cpu_vda),
    .cpu_vpa   (cpu_vpa),
    .cpu_bank  (cpu_bank),
    .hsclk_sel (hsclk_sel),
    .cpu_rdy   (cpu_rdy),
    .speed_fast(speed_fast)
  );

  initial forever #5 hsclk_in = ~hsclk_in;

  initial forever begin
    @(posedge hsclk_in);
    cyc++;
  end

  function automatic logic [2:0] outs();
    return {hsclk_sel, cpu_rdy, speed_fast};
  endfunction

  task automatic chk_val(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: sel/rdy/fast observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each observed output change pops one expectation.
  initial forever begin
    logic [2:0] obs;
    exp_t       e;
    @(negedge hsclk_in);
    obs = outs();
    if (obs !== mon_prev) begin
      if (sb_q.size() == 0) begin
        chk_val("unexpected_change", obs, mon_prev);
      end else begin
        e = sb_q.pop_front();
        chk_val(e.tag, obs, e.val);
        if (e.at_cyc >= 0) chk_int({e.tag, "_cycle"}, cyc, e.at_cyc);
      end
      mon_prev = obs;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge hsclk_in);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] v, input int at);
    exp_t e;
    e.tag    = tag;
    e.val    = v;
    e.at_cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic ls_rise(output int rc);
    lsclk_in = 1'b1;
    rc = cyc;
  endtask

  task automatic ls_finish();
    tick(4);
    lsclk_in = 1'b0;
    tick(4);
  endtask

  task automatic ls_cycles(input int n);
    repeat (n) begin
      lsclk_in = 1'b1;
      tick(4);
      lsclk_in = 1'b0;
      tick(4);
    end
  endtask

  task automatic host_access(input logic [7:0] bank, input logic vda, input logic vpa,
                             input logic strobe);
    cpu_bank  = bank;
    cpu_vda   = vda;
    cpu_vpa   = vpa;
    cyc_start = strobe;
    tick(1);
    cyc_start = 1'b0;
    cpu_vda   = 1'b0;
    cpu_vpa   = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk_int({tag, "_drained"}, sb_q.size(), 0);
    if (sb_q.size() != 0) sb_q.delete();
  endtask

  initial begin
    int r;
    int t;

    // Reset and synchronous release
    #2 rst_b = 1'b0;
    tick(3);
    chk_val("reset_outputs", outs(), 3'b010);
    rst_b = 1'b1;
    tick(6);
    chk_val("post_reset_idle", outs(), 3'b010);

    // Boot: four host edges of hold, then 16 settle cycles
    ls_cycles(3);
    ls_rise(r);
    expect_out("boot_to_fast", 3'b100, r + 4);
    expect_out("boot_fast", 3'b111, r + 20);
    ls_finish();
    drain("boot", 40);

    // Non-host or unqualified cycles leave FAST alone
    host_access(8'h7E, 1'b1, 1'b0, 1'b1);
    host_access(8'hFF, 1'b0, 1'b0, 1'b1);
    host_access(8'hFF, 1'b1, 1'b1, 1'b0);
    tick(3);
    chk_val("fast_no_host", outs(), 3'b111);

    // Host access in FAST: stall until the 2nd synchronized lsclk edge
    t = cyc;
    expect_out("host_to_slow", 3'b000, t + 1);
    host_access(8'hFF, 1'b1, 1'b0, 1'b1);
    ls_cycles(1);
    ls_rise(r);
    expect_out("host_slow", 3'b010, r + 3);
    ls_finish();
    drain("host_slow", 10);

    // Repeated accesses keep SLOW; access on the hold-0 cycle reloads
    repeat (3) begin
      host_access(8'hFF, 1'b1, 1'b0, 1'b1);
      ls_cycles(3);
    end
    host_access(8'hFF, 1'b0, 1'b1, 1'b1);
    ls_cycles(3);
    ls_rise(r);
    tick(3);
    host_access(8'hFF, 1'b1, 1'b0, 1'b1);
    lsclk_in = 1'b0;
    tick(4);
    chk_val("hold0_host_stays_slow", outs(), 3'b010);

    // Accesses stop: TO_FAST four edges later; disable during TO_FAST is deferred
    ls_cycles(3);
    ls_rise(r);
    expect_out("hold_to_fast", 3'b100, r + 4);
    expect_out("fast_despite_disable", 3'b111, r + 20);
    expect_out("to_slow_after_fast", 3'b000, r + 21);
    ls_finish();
    hs_enable = 1'b0;
    host_access(8'hFF, 1'b1, 1'b0, 1'b1);
    drain("disable_in_to_fast", 40);

    // Enable rising during TO_SLOW does not abort it
    hs_enable = 1'b1;
    ls_cycles(1);
    ls_rise(r);
    expect_out("slow_after_enable_rise", 3'b010, r + 3);
    ls_finish();
    drain("enable_in_to_slow", 10);
    ls_cycles(3);
    ls_rise(r);
    expect_out("reenable_to_fast", 3'b100, r + 4);
    expect_out("reenable_fast", 3'b111, r + 20);
    ls_finish();
    drain("reenable", 40);

    // Disable in FAST, hold saturates, then enable restarts speed-up at once
    t = cyc;
    expect_out("to_slow_on_disable", 3'b000, t + 1);
    hs_enable = 1'b0;
    tick(1);
    ls_cycles(1);
    ls_rise(r);
    expect_out("slow_disabled", 3'b010, r + 3);
    ls_finish();
    drain("disable_fast", 10);
    ls_cycles(5);
    chk_val("slow_while_disabled", outs(), 3'b010);
    t = cyc;
    expect_out("to_fast_on_enable", 3'b100, t + 1);
    hs_enable = 1'b1;
    tick(1);
    drain("enable_slow", 5);

    // Reset during TO_FAST
    tick(3);
    expect_out("rst_in_to_fast", 3'b010, -1);
    #2 rst_b = 1'b0;
    #1 chk_val("rst_async_to_fast", outs(), 3'b010);
    tick(2);
    rst_b = 1'b1;
    tick(4);
    chk_val("post_rst_to_fast", outs(), 3'b010);
    drain("rst_to_fast", 5);
    ls_cycles(3);
    ls_rise(r);
    expect_out("rst_then_to_fast", 3'b100, r + 4);
    expect_out("rst_then_fast", 3'b111, r + 20);
    ls_finish();
    drain("rst_then_fast", 40);

    // Reset during TO_SLOW
    t = cyc;
    expect_out("vpa_to_slow", 3'b000, t + 1);
    host_access(8'hFF, 1'b0, 1'b1, 1'b1);
    drain("vpa_to_slow", 5);
    ls_cycles(1);
    expect_out("rst_in_to_slow", 3'b010, -1);
    #2 rst_b = 1'b0;
    #1 chk_val("rst_async_to_slow", outs(), 3'b010);
    tick(2);
    rst_b = 1'b1;
    drain("rst_to_slow", 5);
    tick(10);
    chk_val("slow_after_rst_release", outs(), 3'b010);

    tick(2);
    chk_int("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
